// File: rtl/smpc_pad_scanner.sv
// SMPC peripheral-port sequencer: walks TH/TR select codes on each enabled port, formats peripheral bytes into OREG.
// Latency per port: 4*(SETTLE+2) CE ticks of scanning, then one CE tick per emitted byte, plus NEXT and FIN ticks.
// Backpressure: none; the OREG write port always accepts, and CE=0 freezes all state and masks the strobes.
module smpc_pad_scanner #(
  parameter int SETTLE    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       CE,
  input  logic       START,
  input  logic [1:0] PORT_EN,
  output logic       BUSY,
  output logic       DONE,
  output logic       OUT_WE,
  output logic [4:0] OUT_ADDR,
  output logic [7:0] OUT_DATA,
  output logic [4:0] OUT_LEN,
  input  logic [6:0] P1I,
  output logic [6:0] P1O,
  input  logic [6:0] P2I,
  output logic [6:0] P2O
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEL, S_SETTLE, S_SAMPLE, S_EMIT, S_NEXT, S_FIN
  } state_t;

  localparam logic [6:0] PORT_IDLE = 7'h60;

  state_t           state, state_nx;
  logic [1:0]       phase;
  logic             port;        // 0 = port 1, 1 = port 2
  logic [1:0]       pen;
  logic [7:0]       cnt;
  logic [3:0][3:0]  nib;
  logic [4:0]       addr, len, out_len;
  logic [1:0]       bidx;
  logic [2:0]       nbytes;
  logic [7:0]       byte_dat;
  logic             last_byte;
  logic [6:0]       p1o_q, p2o_q;
  logic             unused_pins;

  // Only the data nibble of each port is read; TH/TR/bit4 echo back what we drive.
  assign unused_pins = ^{P1I[6:4], P2I[6:4]};

  assign OUT_ADDR = addr;
  assign OUT_LEN  = out_len;
  assign P1O      = p1o_q;
  assign P2O      = p2o_q;

  // Classify the device from nib3 and pick the byte for the current emit slot.
  always_comb begin
    nbytes   = 3'd2;
    byte_dat = 8'hFF;
    if (nib[3] == 4'hF) begin
      nbytes   = 3'd1;
      byte_dat = 8'hF0;
    end else if (nib[3][2:0] == 3'b100) begin
      nbytes = 3'd4;
      case (bidx)
        2'd0:    byte_dat = 8'hF1;
        2'd1:    byte_dat = 8'h02;
        2'd2:    byte_dat = {nib[0], nib[1]};
        default: byte_dat = {nib[2], nib[3][3], 3'b111};
      endcase
    end else if (bidx == 2'd0) begin
      byte_dat = 8'hF1;
    end
  end

  assign last_byte = ({1'b0, bidx} == (nbytes - 3'd1));

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state decode and state-derived outputs; strobes are masked when CE is low.
  always_comb begin
    state_nx = state;
    if (CE) begin
      case (state)
        S_IDLE:   if (START) state_nx = (PORT_EN != 2'b00) ? S_SEL : S_FIN;
        S_SEL:    state_nx = S_SETTLE;
        S_SETTLE: if (cnt <= 8'd1) state_nx = S_SAMPLE;
        S_SAMPLE: state_nx = (phase == 2'd3) ? S_EMIT : S_SEL;
        S_EMIT:   if (last_byte) state_nx = S_NEXT;
        S_NEXT:   state_nx = (!port && pen[1]) ? S_SEL : S_FIN;
        S_FIN:    state_nx = S_IDLE;
        default:  state_nx = S_IDLE;
      endcase
    end
    BUSY     = (state != S_IDLE) && (state != S_FIN);
    DONE     = CE && (state == S_FIN);
    OUT_WE   = CE && (state == S_EMIT);
    OUT_DATA = (state == S_EMIT) ? byte_dat : 8'h00;
  end

  // Datapath: select drive, settle timer, nibble capture, address/length counters.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      phase   <= 2'd0;
      port    <= 1'b0;
      pen     <= 2'b00;
      cnt     <= 8'd0;
      nib     <= '0;
      addr    <= 5'(BASE_ADDR);
      len     <= 5'd0;
      out_len <= 5'd0;
      bidx    <= 2'd0;
      p1o_q   <= PORT_IDLE;
      p2o_q   <= PORT_IDLE;
    end else if (CE) begin
      case (state)
        S_IDLE: if (START) begin
          pen   <= PORT_EN;
          phase <= 2'd0;
          port  <= ~PORT_EN[0];
          addr  <= 5'(BASE_ADDR);
          len   <= 5'd0;
          if (PORT_EN == 2'b00) out_len <= 5'd0;
        end
        S_SEL: begin
          cnt <= 8'(SETTLE);
          if (port) p2o_q <= {phase, 5'b0};
          else      p1o_q <= {phase, 5'b0};
        end
        S_SETTLE: cnt <= cnt - 8'd1;
        S_SAMPLE: begin
          nib[phase] <= port ? P2I[3:0] : P1I[3:0];
          phase      <= phase + 2'd1;
          bidx       <= 2'd0;
        end
        S_EMIT: begin
          addr <= addr + 5'd1;
          len  <= len + 5'd1;
          bidx <= bidx + 2'd1;
        end
        S_NEXT: begin
          if (port) p2o_q <= PORT_IDLE;
          else      p1o_q <= PORT_IDLE;
          if (!port && pen[1]) begin
            port  <= 1'b1;
            phase <= 2'd0;
          end else begin
            out_len <= len;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_smpc_pad_scanner.sv
// Bench for smpc_pad_scanner: two instances (BASE_ADDR 0 and 30) share stimulus and a device model.
// Expected writes and lengths are queued at START and popped as the DUTs emit them.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_smpc_pad_scanner;

  logic       clk = 1'b0, rst_n = 1'b0, ce = 1'b1, start = 1'b0;
  logic [1:0] port_en = 2'b00;
  logic       a_busy, a_done, a_we, b_busy, b_done, b_we;
  logic [4:0] a_addr, a_len, b_addr, b_len;
  logic [7:0] a_data, b_data;
  logic [6:0] a_p1o, a_p2o, b_p1o, b_p2o, p1i, p2i;
  logic [3:0][3:0] tbl1, tbl2;

  int checks = 0, errors = 0, done_cnt = 0, dones_exp = 0, ce_ph = 0;
  bit ce_div = 1'b0;
  logic [12:0] qa[$], qb[$];
  logic [4:0]  qlen[$];
  logic [6:0]  p1_log[$], p2_log[$];
  logic [6:0]  p1_last = 7'h60, p2_last = 7'h60;

  always #5 clk = ~clk;

  // Device model: returns the table nibble selected by the {TH,TR} we are driven with.
  assign p1i = {a_p1o[6:5], 1'b0, tbl1[a_p1o[6:5]]};
  assign p2i = {a_p2o[6:5], 1'b0, tbl2[a_p2o[6:5]]};

  smpc_pad_scanner #(.SETTLE(4), .BASE_ADDR(0)) u_a (
    .CLK(clk), .RST_N(rst_n), .CE(ce), .START(start), .PORT_EN(port_en),
    .BUSY(a_busy), .DONE(a_done), .OUT_WE(a_we), .OUT_ADDR(a_addr), .OUT_DATA(a_data),
    .OUT_LEN(a_len), .P1I(p1i), .P1O(a_p1o), .P2I(p2i), .P2O(a_p2o));

  smpc_pad_scanner #(.SETTLE(4), .BASE_ADDR(30)) u_b (
    .CLK(clk), .RST_N(rst_n), .CE(ce), .START(start), .PORT_EN(port_en),
    .BUSY(b_busy), .DONE(b_done), .OUT_WE(b_we), .OUT_ADDR(b_addr), .OUT_DATA(b_data),
    .OUT_LEN(b_len), .P1I(p1i), .P1O(b_p1o), .P2I(p2i), .P2O(b_p2o));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold START until it has been seen on a CE tick.
  task automatic do_start(input logic [1:0] pen);
    start   = 1'b1;
    port_en = pen;
    do @(posedge clk); while (!ce);
    #1;
    start = 1'b0;
  endtask

  // Queue the bytes one enabled port should produce.
  task automatic add_port(input logic [3:0][3:0] t, inout logic [7:0] bytes[$]);
    if (t[3] == 4'hF) begin
      bytes.push_back(8'hF0);
    end else if (t[3][2:0] == 3'b100) begin
      bytes.push_back(8'hF1);
      bytes.push_back(8'h02);
      bytes.push_back({t[0], t[1]});
      bytes.push_back({t[2], t[3][3], 3'b111});
    end else begin
      bytes.push_back(8'hF1);
      bytes.push_back(8'hFF);
    end
  endtask

  task automatic expect_scan(input logic [1:0] pen);
    logic [7:0] bytes[$];
    if (pen[0]) add_port(tbl1, bytes);
    if (pen[1]) add_port(tbl2, bytes);
    for (int i = 0; i < bytes.size(); i++) begin
      qa.push_back({5'(i), bytes[i]});
      qb.push_back({5'(30 + i), bytes[i]});
    end
    qlen.push_back(5'(bytes.size()));
    dones_exp++;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (done_cnt < dones_exp && n < budget) begin
      tick();
      n++;
    end
    checks++;
    assert (done_cnt >= dones_exp) else begin
      errors++;
      $error("FAIL %s done count %0d expected %0d within %0d cycles", tag, done_cnt, dones_exp, budget);
    end
  endtask

  task automatic check_drained(input string tag);
    checks++;
    assert (qa.size() == 0 && qb.size() == 0 && qlen.size() == 0) else begin
      errors++;
      $error("FAIL %s pending writes a=%0d b=%0d dones=%0d expected 0", tag, qa.size(), qb.size(), qlen.size());
    end
  endtask

  task automatic check_sel_log(input string tag, input logic [6:0] lg[$], input bit active);
    logic [6:0] seq[4];
    seq = '{7'h00, 7'h20, 7'h40, 7'h60};
    checks++;
    assert (lg.size() == (active ? 4 : 0)) else begin
      errors++;
      $error("FAIL %s select changes %0d expected %0d", tag, lg.size(), active ? 4 : 0);
    end
    if (active && lg.size() == 4)
      for (int i = 0; i < 4; i++) begin
        checks++;
        assert (lg[i] === seq[i]) else begin
          errors++;
          $error("FAIL %s step %0d drive %h expected %h", tag, i, lg[i], seq[i]);
        end
      end
  endtask

  task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [12:0] e;
    logic [4:0]  el;
    tbl1 = '1;
    tbl2 = '1;
    fork
      // Clock-enable generator: every cycle, or one cycle in three.
      forever begin
        @(posedge clk);
        #1;
        if (ce_div) begin
          ce_ph = (ce_ph + 1) % 3;
          ce = (ce_ph == 0);
        end else begin
          ce = 1'b1;
        end
      end
      // Output monitor: scoreboard writes and DONE, log select drive changes.
      forever begin
        @(negedge clk);
        if (p1_last !== a_p1o) begin p1_log.push_back(a_p1o); p1_last = a_p1o; end
        if (p2_last !== a_p2o) begin p2_log.push_back(a_p2o); p2_last = a_p2o; end
        if (rst_n) begin
          if (a_we) begin
            checks++;
            assert (qa.size() != 0) else begin
              errors++;
              $error("FAIL wr_a unexpected write addr %0d data %h expected none", a_addr, a_data);
            end
            if (qa.size() != 0) begin
              e = qa.pop_front();
              chk("wr_a", {a_addr, a_data}, e);
            end
          end
          if (b_we) begin
            checks++;
            assert (qb.size() != 0) else begin
              errors++;
              $error("FAIL wr_b unexpected write addr %0d data %h expected none", b_addr, b_data);
            end
            if (qb.size() != 0) begin
              e = qb.pop_front();
              chk("wr_b", {b_addr, b_data}, e);
            end
          end
          if (a_done) begin
            done_cnt++;
            checks++;
            assert (qlen.size() != 0) else begin
              errors++;
              $error("FAIL done unexpected pulse len %0d expected none", a_len);
            end
            if (qlen.size() != 0) begin
              el = qlen.pop_front();
              chk("len_a", 13'(a_len), 13'(el));
              chk("len_b", 13'(b_len), 13'(el));
            end
            chk("done_b", 13'(b_done), 13'd1);
          end
        end
      end
    join_none

    // Reset state.
    repeat (2) tick();
    chk("rst_busy", 13'(a_busy), 13'd0);
    chk("rst_done_we", {11'd0, a_done, a_we}, 13'd0);
    chk("rst_addr_a", 13'(a_addr), 13'd0);
    chk("rst_addr_b", 13'(b_addr), 13'd30);
    chk("rst_data_len", {a_len, a_data}, 13'd0);
    chk("rst_pxo", {a_p1o, 6'(a_p2o[6:1])}, {7'h60, 6'h30});
    rst_n = 1'b1;
    repeat (2) tick();

    // Reset asserted mid-SETTLE aborts the scan.
    tbl1 = {4'hC, 4'hC, 4'h5, 4'hA};
    do_start(2'b01);
    repeat (4) tick();
    chk("mid_busy", 13'(a_busy), 13'd1);
    chk("mid_p1o", 13'(a_p1o), 13'h00);
    rst_n = 1'b0;
    #1;
    chk("abort_p1o", 13'(a_p1o), 13'h60);
    chk("abort_p2o", 13'(a_p2o), 13'h60);
    chk("abort_busy_we", {11'd0, a_busy, a_we}, 13'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Pad on port 1: F1 02 A5 CF.
    p1_log.delete();
    p2_log.delete();
    expect_scan(2'b01);
    do_start(2'b01);
    wait_done(200, "pad_p1");
    tick();
    check_drained("pad_p1");
    check_sel_log("pad_p1_sel", p1_log, 1'b1);
    check_sel_log("pad_p1_p2idle", p2_log, 1'b0);

    // Both ports, port 2 empty: F1 02 39 67 F0 (instance b wraps 30,31,0,1,2).
    tbl1 = {4'b0100, 4'h6, 4'h9, 4'h3};
    tbl2 = '1;
    expect_scan(2'b11);
    do_start(2'b11);
    wait_done(300, "both_empty2");
    tick();
    check_drained("both_empty2");

    // Unknown device on port 2 only: F1 FF; port 1 never driven.
    tbl2 = {4'b0010, 4'h3, 4'h2, 4'h1};
    p1_log.delete();
    p2_log.delete();
    expect_scan(2'b10);
    do_start(2'b10);
    wait_done(200, "unk_p2");
    tick();
    check_drained("unk_p2");
    check_sel_log("unk_p2_p1idle", p1_log, 1'b0);
    check_sel_log("unk_p2_sel", p2_log, 1'b1);

    // CE one-in-three, START and PORT_EN changed while busy are ignored.
    tbl1 = {4'hC, 4'hC, 4'h5, 4'hA};
    ce_div = 1'b1;
    expect_scan(2'b11);
    do_start(2'b11);
    repeat (20) tick();
    do_start(2'b01);
    wait_done(600, "ce_div");
    repeat (60) tick();
    chk("ce_div_one_done", 13'(done_cnt), 13'(dones_exp));
    chk("ce_div_idle", 13'(a_busy), 13'd0);
    check_drained("ce_div");
    ce_div = 1'b0;
    repeat (3) tick();

    // PORT_EN=00: immediate DONE with length 0 and no writes.
    expect_scan(2'b00);
    do_start(2'b00);
    wait_done(3, "pen00");
    repeat (3) tick();
    check_drained("pen00");
    chk("pen00_len", 13'(a_len), 13'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
